// File: rtl/matrix_stream_sequencer_if.sv
// Byte-in / word-out stream bundle between the matrix sequencer and its environment.
// The sequencer takes the slave side; the producer/consumer takes the master side.
interface matrix_stream_sequencer_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/matrix_stream_sequencer.sv
// Loads 4x4 byte operands A then B from a stream, captures the multiplier's product
// one cycle later, and streams the 16 result words out row-major.
module matrix_stream_sequencer (
   input  logic                      clk,
   input  logic                      rst,
   matrix_stream_sequencer_if.slave  strm,
   output logic [0:3][0:3][7:0]      matrixA,
   output logic [0:3][0:3][7:0]      matrixB,
   input  logic [0:3][0:3][15:0]     matrixC,
   output logic                      busy
);

   typedef enum logic [1:0] {StLoadA, StLoadB, StSettle, StSend} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              idx_q, idx_d;
   logic [0:3][0:3][7:0]    mat_a_q, mat_a_d;
   logic [0:3][0:3][7:0]    mat_b_q, mat_b_d;
   logic [0:15][15:0]       res_q, res_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StLoadA;
         idx_q   <= '0;
         mat_a_q <= '0;
         mat_b_q <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mat_a_q <= mat_a_d;
         mat_b_q <= mat_b_d;
         res_q   <= res_d;
      end
   end

   // Handshake outputs decode from state/idx only; in_valid and out_ready only steer next state.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      mat_a_d        = mat_a_q;
      mat_b_d        = mat_b_q;
      res_d          = res_q;
      strm.in_ready  = 1'b0;
      strm.out_valid = 1'b0;
      strm.out_last  = 1'b0;
      strm.out_data  = '0;

      unique case (state_q)
         StLoadA: begin
            strm.in_ready = 1'b1;
            if (strm.in_valid) begin
               mat_a_d[idx_q[3:2]][idx_q[1:0]] = strm.in_data;
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd15) state_d = StLoadB;
            end
         end
         StLoadB: begin
            strm.in_ready = 1'b1;
            if (strm.in_valid) begin
               mat_b_d[idx_q[3:2]][idx_q[1:0]] = strm.in_data;
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd15) state_d = StSettle;
            end
         end
         StSettle: begin
            for (int unsigned e = 0; e < 16; e++) begin
               res_d[e[3:0]] = matrixC[e[3:2]][e[1:0]];
            end
            state_d = StSend;
         end
         StSend: begin
            strm.out_valid = 1'b1;
            strm.out_data  = res_q[idx_q];
            strm.out_last  = (idx_q == 4'd15);
            if (strm.out_ready) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd15) state_d = StLoadA;
            end
         end
         default: begin
            state_d = StLoadA;
            idx_d   = '0;
         end
      endcase

      busy = (state_q != StLoadA) || (idx_q != 4'd0);
   end

   assign matrixA = mat_a_q;
   assign matrixB = mat_b_q;

endmodule

// File: tb/tb_matrix_stream_sequencer.sv
// Directed bench for matrix_stream_sequencer with a behavioural 4x4 multiplier on matrixC.
module tb_matrix_stream_sequencer;

   typedef logic [7:0]  bytes_t [16];
   typedef logic [15:0] words_t [16];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matrix_stream_sequencer_if ifc ();
   logic [0:3][0:3][7:0]  mat_a;
   logic [0:3][0:3][7:0]  mat_b;
   logic [0:3][0:3][15:0] mat_c;
   logic                  busy;

   matrix_stream_sequencer dut (
      .clk     (clk),
      .rst     (rst),
      .strm    (ifc),
      .matrixA (mat_a),
      .matrixB (mat_b),
      .matrixC (mat_c),
      .busy    (busy)
   );

   // Combinational multiplier stand-in, modulo 2^16.
   always_comb begin
      mat_c = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
               mat_c[r[1:0]][c[1:0]] = mat_c[r[1:0]][c[1:0]]
                  + 16'(mat_a[r[1:0]][k[1:0]]) * 16'(mat_b[k[1:0]][c[1:0]]);
   end

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (mon_en) check_eq("in_out_mutex", ifc.in_ready & ifc.out_valid, 0);

   task automatic push_byte(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) begin
         @(negedge clk);
         ifc.in_valid = 1'b0;
      end
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_data  = b;
      while (!ifc.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check_eq("push_timeout", t, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic push_job(input bytes_t a, input bytes_t b, input int max_gap);
      for (int i = 0; i < 16; i++) push_byte(a[i], max_gap > 0 ? $urandom_range(0, max_gap) : 0);
      for (int i = 0; i < 16; i++) push_byte(b[i], max_gap > 0 ? $urandom_range(0, max_gap) : 0);
   endtask

   task automatic pull(input int n, input words_t exp, input bit stall, input string tag);
      int i = 0;
      int t = 0;
      while (i < n && t < 500) begin
         @(negedge clk);
         t++;
         if (ifc.out_valid) begin
            check_eq({tag, "_data"}, ifc.out_data, exp[i]);
            check_eq({tag, "_last"}, ifc.out_last, (i == 15));
            ifc.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ifc.out_ready) i++;
         end else begin
            ifc.out_ready = 1'b0;
         end
      end
      if (i < n) check_eq({tag, "_timeout"}, i, n);
      if (n == 16) begin
         @(negedge clk);
         check_eq({tag, "_done_valid"}, ifc.out_valid, 0);
         check_eq({tag, "_done_ready"}, ifc.in_ready, 1);
      end
   endtask

   bytes_t a_id, a_id2, a_ones, a_ff, b_seq, b_bp, b_hi;
   words_t e_seq, e_bp, e_dbl, e_ff, e_cols, e_hi;
   int     cnt;

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         a_id[i]   = (i % 5 == 0) ? 8'd1 : 8'd0;
         a_id2[i]  = (i % 5 == 0) ? 8'd2 : 8'd0;
         a_ones[i] = 8'd1;
         a_ff[i]   = 8'd255;
         b_seq[i]  = 8'(i + 1);
         b_bp[i]   = 8'(100 + 3 * i);
         b_hi[i]   = 8'(200 + i);
         e_seq[i]  = 16'(i + 1);
         e_bp[i]   = 16'(100 + 3 * i);
         e_dbl[i]  = 16'(2 * (i + 1));
         e_ff[i]   = 16'd63492;
         e_cols[i] = 16'(28 + 4 * (i % 4));
         e_hi[i]   = 16'(200 + i);
      end
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.out_ready = 1'b0;

      #12;
      check_eq("rst_in_ready", ifc.in_ready, 1);
      check_eq("rst_out_valid", ifc.out_valid, 0);
      check_eq("rst_out_last", ifc.out_last, 0);
      check_eq("rst_out_data", ifc.out_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_matrix_a", mat_a, 0);
      check_eq("rst_matrix_b", mat_b, 0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      // Identity job: first out_valid exactly one cycle after the 32nd byte.
      push_job(a_id, b_seq, 0);
      ifc.in_valid = 1'b0;
      @(negedge clk);
      check_eq("settle_out_valid", ifc.out_valid, 0);
      check_eq("settle_in_ready", ifc.in_ready, 0);
      check_eq("settle_busy", busy, 1);
      @(negedge clk);
      check_eq("first_valid_latency", ifc.out_valid, 1);
      pull(16, e_seq, 1'b0, "identity");

      push_job(a_ff, a_ff, 0);
      ifc.in_valid = 1'b0;
      pull(16, e_ff, 1'b0, "overflow");

      push_job(a_id, b_bp, 3);
      ifc.in_valid = 1'b0;
      pull(16, e_bp, 1'b1, "backpressure");

      // Reset after 20 bytes: A complete, B partially loaded.
      for (int i = 0; i < 16; i++) push_byte(a_ones[i], 0);
      for (int i = 0; i < 4; i++) push_byte(b_hi[i], 0);
      ifc.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("midload_matrix_a", mat_a, 0);
      check_eq("midload_matrix_b", mat_b, 0);
      check_eq("midload_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      push_job(a_id2, b_seq, 0);
      ifc.in_valid = 1'b0;
      pull(16, e_dbl, 1'b0, "fresh");

      // Reset after 5 words have been sent.
      push_job(a_id, b_seq, 0);
      ifc.in_valid = 1'b0;
      pull(5, e_seq, 1'b0, "midsend");
      @(negedge clk);
      check_eq("midsend_word5", ifc.out_data, 6);
      rst = 1'b1;
      #1;
      check_eq("midsend_out_valid", ifc.out_valid, 0);
      check_eq("midsend_in_ready", ifc.in_ready, 1);
      check_eq("midsend_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      ifc.out_ready = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (ifc.out_valid) cnt++;
      end
      check_eq("midsend_no_more_words", cnt, 0);

      // Back-to-back jobs with in_valid held high throughout.
      fork
         begin
            push_job(a_ones, b_seq, 0);
            push_job(a_id, b_hi, 0);
            ifc.in_valid = 1'b0;
         end
         begin
            pull(16, e_cols, 1'b0, "b2b_job1");
            pull(16, e_hi, 1'b0, "b2b_job2");
         end
      join

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
